edge_event_filter: RTL

//  Multi-channel, glitch-filtered edge detector with sticky event flags and a summary interrupt.

---
 rtl/edge_event_pkg.sv | 18 +
 rtl/edge_filter_channel.sv | 66 ++++++
 rtl/edge_event_filter.sv | 53 +++++
 3 files changed

// File: rtl/edge_event_pkg.sv
// Shared types and helpers for the edge event filter.
// Counter sizing and the edge direction classification used per channel.
package edge_event_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_dir_e;

  // Width that holds 0..filter_cycles-1, never narrower than one bit.
  function automatic int unsigned FILTER_CNT_W(input int unsigned filter_cycles);
    int unsigned w;
    w = $clog2(filter_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/edge_filter_channel.sv
// One debounced channel: optional 2-flop synchroniser, agreement counter, level and edge pulses.
// Synchroniser present only when EDGE_EVENT_SYNC_EN is defined.
module edge_filter_channel
  import edge_event_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic level,
  output logic rising,
  output logic falling
);

  localparam int unsigned CW = FILTER_CNT_W(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

  logic          sample;
  logic [CW-1:0] cnt;
  edge_dir_e     dir;

`ifdef EDGE_EVENT_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], in};
    end
  end

  assign sample = sync_q[1];
`else
  assign sample = in;
`endif

  always_comb begin
    dir = EDGE_NONE;
    if ((sample != level) && (cnt == CNT_MAX)) begin
      dir = sample ? EDGE_RISE : EDGE_FALL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level   <= 1'b0;
      cnt     <= '0;
      rising  <= 1'b0;
      falling <= 1'b0;
    end else begin
      rising  <= (dir == EDGE_RISE);
      falling <= (dir == EDGE_FALL);
      if (sample == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sample;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/edge_event_filter.sv
// Multi-channel glitch-filtered edge detector with sticky pending flags and summary irq.
// Define EDGE_EVENT_SYNC_EN to add a 2-flop input synchroniser per channel.
module edge_event_filter
  import edge_event_pkg::*;
#(
  parameter int unsigned CHANNELS      = 8,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in,
  input  logic [CHANNELS-1:0] rise_en,
  input  logic [CHANNELS-1:0] fall_en,
  input  logic [CHANNELS-1:0] clear,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rising,
  output logic [CHANNELS-1:0] falling,
  output logic [CHANNELS-1:0] pending,
  output logic                irq
);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("edge_event_filter: CHANNELS must be >= 1");
  end
  if (FILTER_CYCLES < 1) begin : g_bad_filter
    $error("edge_event_filter: FILTER_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    edge_filter_channel #(
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .in     (in[i]),
      .level  (level[i]),
      .rising (rising[i]),
      .falling(falling[i])
    );
  end

  // Set terms are OR'd after the clear so a coincident clear never drops an event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clear) | (rising & rise_en) | (falling & fall_en);
    end
  end

  assign irq = |pending;

endmodule
